// File: rtl/dmem_bus_arbiter.sv
// Round-robin two-master arbiter for the shared data-memory bus port.
// Optional slave-timeout abort is built when ARB_TIMEOUT_EN is defined.
module dmem_bus_arbiter #(
  parameter int unsigned DWidth        = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_write_i,
  input  logic [DWidth-1:0] m0_addr_i,
  input  logic [DWidth-1:0] m0_wdata_i,
  output logic              m0_ready_o,
  output logic [DWidth-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_write_i,
  input  logic [DWidth-1:0] m1_addr_i,
  input  logic [DWidth-1:0] m1_wdata_i,
  output logic              m1_ready_o,
  output logic [DWidth-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              trans_o,
  output logic              write_o,
  output logic [DWidth-1:0] addr_o,
  output logic [DWidth-1:0] wdata_o,
  input  logic              ready_i,
  input  logic [DWidth-1:0] rdata_i,
  output logic              owner_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;

  logic   busy_c;
  logic   any_req_c;
  logic   grant_c;
  logic   timeout_c;
  logic   done_c;
  logic   sel0_c;
  logic   sel1_c;

  assign busy_c    = (state == BUSY);
  assign any_req_c = m0_req_i | m1_req_i;
  // Master 1 wins when alone, or on a tie when master 0 was served last.
  assign grant_c   = m1_req_i & (~m0_req_i | ~last_grant);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

  logic [CntW-1:0] wait_cnt;

  // Counts BUSY cycles without slave completion; cleared while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (!busy_c) begin
      wait_cnt <= '0;
    end else if (!ready_i) begin
      wait_cnt <= wait_cnt + CntW'(1);
    end
  end

  assign timeout_c = busy_c & ~ready_i & (wait_cnt == CntW'(TimeoutCycles - 1));
`else
  // The timeout depth only matters when the abort feature is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_c          = 1'b0;
`endif

  assign done_c = busy_c & (ready_i | timeout_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req_c) begin
            owner <= grant_c;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done_c) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel0_c = busy_c & ~owner;
  assign sel1_c = busy_c & owner;

  // Downstream request is the owner's request, quiet while idle.
  assign trans_o = busy_c;
  assign write_o = sel1_c ? m1_write_i : (sel0_c ? m0_write_i : 1'b0);
  assign addr_o  = sel1_c ? m1_addr_i  : (sel0_c ? m0_addr_i  : '0);
  assign wdata_o = sel1_c ? m1_wdata_i : (sel0_c ? m0_wdata_i : '0);
  assign owner_o = owner;

  assign m0_ready_o = sel0_c & done_c;
  assign m1_ready_o = sel1_c & done_c;
  assign m0_rdata_o = (sel0_c & ready_i) ? rdata_i : '0;
  assign m1_rdata_o = (sel1_c & ready_i) ? rdata_i : '0;
  assign m0_err_o   = sel0_c & timeout_c;
  assign m1_err_o   = sel1_c & timeout_c;

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Two-master arbiter that shares the single data-memory bus port between the CPU (master 0) and a second requester such as a DMA or NPU loader (master 1).
- Sits between the masters and the bus decoder/slave side. It presents one request stream downstream and returns ready/rdata only to the owning master.
- Arbitration is round-robin with a per-transaction grant.

Parameters:
- DWidth, 32, data/address width.
- TimeoutCycles, 256, cycles in BUSY without slave ready before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- m0_req_i  input  1  master 0 request; held high until m0_ready_o.
- m0_write_i  input  1  master 0 write enable.
- m0_addr_i  input  DWidth  master 0 address.
- m0_wdata_i  input  DWidth  master 0 write data.
- m0_ready_o  output  1  master 0 transfer complete (1-cycle pulse).
- m0_rdata_o  output  DWidth  master 0 read data, valid with m0_ready_o.
- m0_err_o  output  1  master 0 transfer aborted by timeout.
- m1_req_i, m1_write_i, m1_addr_i, m1_wdata_i, m1_ready_o, m1_rdata_o, m1_err_o: same as the m0_* ports, for master 1.
- trans_o  output  1  downstream transfer active.
- write_o  output  1  downstream write.
- addr_o  output  DWidth  downstream address.
- wdata_o  output  DWidth  downstream write data.
- ready_i  input  1  downstream completion.
- rdata_i  input  DWidth  downstream read data.
- owner_o  output  1  index of the current or last granted master (debug/status).

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, owner=0, last_grant=1, so master 0 wins the first tie.
  - trans_o=0; all m*_ready_o/err_o=0; m*_rdata_o=0; write_o/addr_o/wdata_o=0; owner_o=0.
  - Reset mid-transaction drops trans_o immediately and abandons the transfer; no ready is returned.
- FSM states: IDLE, BUSY.
- IDLE:
  - No requests: stay in IDLE.
  - Only one master requesting: grant it.
  - Both requesting: grant the master != last_grant.
  - On grant: register owner and go to BUSY next edge.
- BUSY:
  - trans_o=1.
  - write_o/addr_o/wdata_o are combinational muxes of the owner's inputs; masters hold them stable.
- Completion: ready_i=1 in BUSY.
  - Same cycle: owner's mX_ready_o=1 and mX_rdata_o=rdata_i (combinational pass-through).
  - Non-owner's ready_o stays 0.
  - Next edge: last_grant=owner, state=IDLE.
- Latency:
  - req high at edge N gives trans_o high from N+1.
  - With a zero-wait slave (ready_i already high), mX_ready_o is asserted in the cycle after req.
  - Minimum 2 cycles per transfer: there is a mandatory IDLE cycle between transfers, so a completing master's still-high req is never re-granted.
- ready_i in IDLE is ignored.
- Non-owner rdata_o=0.
- Owner dropping req while BUSY is a protocol violation. The transfer still completes. The bench flags it with an assertion.
- Fairness: under continuous requests from both masters, grants strictly alternate 0,1,0,1…
- Slave resp is not forwarded; m*_err_o is driven only by the timeout feature.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TimeoutCycles)+1 clears on entry to BUSY and increments each BUSY cycle with ready_i=0.
  - When the counter reaches TimeoutCycles-1 with ready_i=0, the owner gets mX_ready_o=1 and mX_err_o=1 for one cycle, with mX_rdata_o=0.
  - The FSM goes to IDLE and trans_o drops next edge.
  - last_grant updates as for a normal completion.
  - ready_i=1 in that same cycle takes precedence as a normal completion (err_o=0).
- Not defined: no counter is built, m*_err_o are tied 0, and BUSY waits indefinitely.

Test Plan:
- Reset, then m0 read to 0x0000_0100, slave returns ready_i=1 one cycle after trans_o with rdata_i=0x1234_5678 -> trans_o high from the cycle after req; m0_ready_o pulses 1 cycle with m0_rdata_o=0x1234_5678; m1_ready_o stays 0.
- Both request from reset, zero-wait slave -> m0 granted first, then m1; owner_o sequence 0,1; addr_o shows m0_addr_i then m1_addr_i; 4 cycles total.
- Both requesting continuously for 8 transfers -> grants alternate 0,1,0,1,0,1,0,1; each master completes 4.
- m1 write 0xCAFE_F00D to 0x0000_2000 with the slave stalling 5 cycles -> write_o=1 and wdata_o=0xCAFE_F00D stable for 6 trans_o cycles; m1_ready_o rises only on ready_i.
- rst_ni pulsed low during a BUSY stall -> trans_o=0 asynchronously; no ready pulse; after release, a pending m1 request is granted (last_grant=1 does not block it when it is the only requester).
- ARB_TIMEOUT_EN, TimeoutCycles=16, slave never ready -> owner ready_o and err_o pulse in the 16th BUSY cycle with rdata 0, then IDLE; without the macro, trans_o stays high indefinitely.
